// File: rtl/pop_cnt_pkg.sv
// Shared types, default sizes and the counter step function for the pop counter bank.
package pop_cnt_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    DUMP = 1'b1
  } pc_state_t;

  localparam int DEF_NUM_CH = 5;
  localparam int DEF_CNT_W  = 5;
  localparam int DEF_IDX_W  = 3;

  typedef struct packed {
    logic        ovf;
    logic [31:0] cnt;
  } cnt_step_t;

  // Next value of a counter whose all-ones value is cnt_max; ovf flags an increment from max.
  function automatic cnt_step_t cnt_step(input logic [31:0] cnt,
                                         input logic [31:0] cnt_max,
                                         input logic        sat);
    cnt_step_t r;
    r.ovf = (cnt == cnt_max);
    if (!r.ovf)   r.cnt = cnt + 32'd1;
    else if (sat) r.cnt = cnt_max;
    else          r.cnt = '0;
    return r;
  endfunction

endpackage

// File: rtl/pop_cnt_chan.sv
// One pop counter: increments on pop, saturates or wraps, sticky overflow, clear-on-read.
module pop_cnt_chan
  import pop_cnt_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             pop,
  input  logic             clr,
  input  logic             sat_mode,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  cnt_step_t        step;
  logic [CNT_W-1:0] cnt_inc;

  assign step    = cnt_step(32'(cnt), 32'(CNT_MAX), sat_mode);
  assign cnt_inc = CNT_W'(step.cnt);

  // A clear in the same cycle as a pop restarts at 1 so the pop is kept.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      cnt <= CNT_W'(pop);
      ovf <= 1'b0;
    end else if (pop) begin
      cnt <= cnt_inc;
      if (step.ovf) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/pop_counter_bank.sv
// Bank of per-channel pop counters with single-channel read and full dump read-out.
//   state | meaning
//   IDLE  | accepts req; single reads complete here
//   DUMP  | streaming channel ptr each cycle, req ignored
module pop_counter_bank
  import pop_cnt_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int IDX_W  = DEF_IDX_W
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic [NUM_CH-1:0] pop,
  input  logic              req,
  input  logic              dump,
  input  logic [IDX_W-1:0]  idx,
  input  logic              clr_on_rd,
  input  logic              sat_mode,
  output logic              valid,
  output logic [CNT_W-1:0]  data_out,
  output logic [IDX_W-1:0]  idx_out,
  output logic              err,
  output logic              busy,
  output logic [NUM_CH-1:0] ovf
);

  localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(NUM_CH - 1);
  localparam logic [IDX_W:0]   NUM_CH_X = (IDX_W + 1)'(NUM_CH);

  pc_state_t         state;
  logic [IDX_W-1:0]  ptr;
  logic              clr_hold;

  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic [NUM_CH-1:0] clr_vec;

  logic              rd_en;
  logic              rd_err;
  logic              rd_clr;
  logic [IDX_W-1:0]  rd_sel;
  logic [CNT_W-1:0]  rd_data;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    pop_cnt_chan #(.CNT_W(CNT_W)) u_chan (
      .clk      (clk),
      .reset_L  (reset_L),
      .pop      (pop[i]),
      .clr      (clr_vec[i]),
      .sat_mode (sat_mode),
      .cnt      (cnt[i]),
      .ovf      (ovf[i])
    );
  end

  always_comb begin
    rd_en  = 1'b0;
    rd_err = 1'b0;
    rd_clr = 1'b0;
    rd_sel = idx;
    case (state)
      IDLE: begin
        if (req) begin
          rd_en  = 1'b1;
          rd_sel = dump ? '0 : idx;
          rd_err = !dump && ({1'b0, idx} >= NUM_CH_X);
          rd_clr = clr_on_rd && !rd_err;
        end
      end
      DUMP: begin
        rd_en  = 1'b1;
        rd_sel = ptr;
        rd_clr = clr_hold;
      end
      default: ;
    endcase
  end

  // Out-of-range selects match no channel, so they read as zero and clear nothing.
  always_comb begin
    rd_data = '0;
    clr_vec = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_sel == IDX_W'(i)) begin
        rd_data    = cnt[i];
        clr_vec[i] = rd_clr;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state    <= IDLE;
      ptr      <= '0;
      clr_hold <= 1'b0;
      valid    <= 1'b0;
      data_out <= '0;
      idx_out  <= '0;
      err      <= 1'b0;
    end else begin
      valid <= rd_en;
      if (rd_en) begin
        data_out <= rd_data;
        idx_out  <= rd_sel;
        err      <= rd_err;
      end
      case (state)
        IDLE: begin
          if (req && dump) begin
            state    <= DUMP;
            ptr      <= IDX_W'(1);
            clr_hold <= clr_on_rd;
          end
        end
        DUMP: begin
          ptr <= ptr + IDX_W'(1);
          if (ptr == LAST_CH) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == DUMP);

endmodule

// File: doc/pop_counter_bank.md
# pop_counter_bank

Parametrised bank of per-channel pop counters with a registered read-out port. Each channel counts the cycles its `pop` line is high. A requester reads one channel or dumps all channels in order, with optional clear-on-read, saturating or wrapping arithmetic, and sticky overflow flags. The bank sits beside the FIFO bank and counts pops per FIFO for checker and statistics logic.

## Interface
- `NUM_CH`, default 5: number of channels/counters (2..16)
- `CNT_W`, default 5: counter width in bits
- `IDX_W`, default 3: index width; must satisfy 2**IDX_W >= NUM_CH
- `clk` in 1: single clock, rising edge
- `reset_L` in 1: reset, asynchronous, active-low
- `pop` in NUM_CH: per-channel increment enable
- `req` in 1: read request, accepted only when `busy`=0
- `dump` in 1: sampled with `req`; 1 = stream all channels, 0 = single channel
- `idx` in IDX_W: channel for a single read, sampled with `req`
- `clr_on_rd` in 1: sampled with `req`; clears each channel as it is read
- `sat_mode` in 1: live; 1 = saturate at 2**CNT_W-1, 0 = wrap to 0
- `valid` out 1: `data_out`/`idx_out` hold a read result this cycle
- `data_out` out CNT_W: counter value
- `idx_out` out IDX_W: channel that `data_out` belongs to
- `err` out 1: qualifies `valid`; requested `idx` >= NUM_CH
- `busy` out 1: a dump is in progress; `req` is ignored while high
- `ovf` out NUM_CH: sticky per-channel overflow flags

## Operation
- Reset (reset_L=0, async): all counters 0, `ovf`=0, `valid`=0, `data_out`=0, `idx_out`=0, `err`=0, `busy`=0, FSM=IDLE.
- Count: on each edge with pop[i]=1, cnt[i]+1 is computed CNT_W bits wide.
  - At max with sat_mode=1: cnt[i] holds at max and ovf[i] is set.
  - At max with sat_mode=0: cnt[i] becomes 0 and ovf[i] is set.
- Clear: a read of channel i with clr_on_rd=1 loads cnt[i] <= pop[i] ? 1 : 0 and clears ovf[i]. A pop in the same cycle is never lost.
- Read data is always the counter value before that edge's update.
- FSM states: IDLE, DUMP. `busy` = (state==DUMP).
  - IDLE, req=1, dump=0: single read. Registers cnt[idx], idx_out=idx, valid=1. If idx>=NUM_CH, registers data_out=0, err=1 and clears nothing. State stays IDLE.
  - IDLE, req=1, dump=1: registers channel 0, sets ptr=1, goes to DUMP. The sampled clr_on_rd is held for the whole dump.
  - DUMP: each edge registers channel ptr and increments ptr. At the edge that registers channel NUM_CH-1, state returns to IDLE.
  - req=1 in DUMP: ignored and not queued.
- `valid` is deasserted at any edge that registers no result. `data_out` and `idx_out` hold their last value when `valid`=0.
- `err` is 0 for every dump word.

## Timing
- Single read: request accepted at edge k. valid=1 in cycle k..k+1, exactly one cycle.
- Dump: valid=1 for NUM_CH consecutive cycles starting the cycle after acceptance, with idx_out = 0,1,…,NUM_CH-1.
  - `busy` is high for the first NUM_CH-1 of those cycles.
  - A req in the last dump cycle is accepted, giving gap-free back-to-back streams.
- Back-to-back single reads: valid=1 every cycle.
- Counter update latency: 1 edge. `ovf` is set at the same edge as the overflowing increment.
- reset_L asserted mid-dump: all outputs drop to reset values immediately (asynchronous). No partial stream resumes after release.

## Structure
- Package `pop_cnt_pkg` holds:
  - state enum `pc_state_t` {IDLE, DUMP}
  - default-parameter constants
  - a function computing the saturating/wrapping next count and the overflow flag
- Sub-module `pop_cnt_chan` is one counter with pop, clear, sat_mode and ovf. It is instantiated NUM_CH times by a generate loop. Read mux, ptr and FSM live in the top level.

## Test plan
- Reset, then pop[2]=1 and pop[0]=1 for 3 cycles, then single read idx=2 -> one cycle later valid=1, data_out=3, idx_out=2, err=0.
- sat_mode=1, pop[1] held 40 cycles (CNT_W=5), read idx=1 -> data_out=31, ovf[1]=1. Repeat with sat_mode=0 -> data_out=8, ovf[1]=1.
- clr_on_rd=1 read of idx=0 (count 3) while pop[0]=1 that same cycle -> data_out=3, then a read 1 cycle later -> data_out=1, ovf[0]=0.
- Counts {1,2,3,4,5}, dump=1 -> 5 consecutive valid cycles, data_out 1..5, idx_out 0..4, busy high 4 cycles. A req mid-dump is ignored.
- idx=6 single read -> valid=1, err=1, data_out=0, all counters unchanged.
- reset_L pulled low during dump word 2 -> valid, busy, counters and ovf at 0 within the same cycle; no valid after release until a new req.
